// File: rtl/alu16_nibble_seq.sv
// alu16_nibble_seq: 16-bit NAND/XOR/ADD/SUB walked through a 4-bit slice LSB nibble first; ALU16_SEQ_FASTLOGIC_EN makes NAND/XOR single-cycle
module alu16_nibble_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [1:0]  req_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_error
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0] op_q, op_d, k_q, k_d;
  logic c_q, c_d, err_q, err_d;
  logic [3:0] an, braw, bsel, nib;
  logic [4:0] sum;
  always_comb begin
    an = a_q[{k_q, 2'b00} +: 4];
    braw = b_q[{k_q, 2'b00} +: 4];
    bsel = op_q[0] ? ~braw : braw;
    sum = {1'b0, an} + {1'b0, bsel} + {4'b0, c_q};
    nib = op_q[1] ? sum[3:0] : op_q[0] ? an ^ braw : ~(an & braw);
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    k_d = k_q;
    c_d = c_q;
    res_d = res_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = EXEC;
        a_d = req_a;
        b_d = req_b;
        op_d = req_op;
        k_d = 2'd0;
        c_d = req_op[0];
        err_d = 1'b0;
      end
      EXEC: begin
        res_d[{k_q, 2'b00} +: 4] = nib;
        c_d = sum[4];
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = DONE;
          err_d = op_q[1] & (an[3] ^ bsel[3] ^ sum[3] ^ sum[4]);
        end
`ifdef ALU16_SEQ_FASTLOGIC_EN
        if (!op_q[1]) begin
          res_d = op_q[0] ? a_q ^ b_q : ~(a_q & b_q);
          state_d = DONE;
        end
`endif
      end
      DONE: state_d = rsp_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      k_q <= '0;
      c_q <= 1'b0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      k_q <= k_d;
      c_q <= c_d;
      res_q <= res_d;
      err_q <= err_d;
    end
  end
  assign req_ready = !rst && state_q == IDLE;
  assign rsp_valid = state_q == DONE;
  assign rsp_result = res_q;
  assign rsp_error = err_q;
endmodule

// File: tb/tb_alu16_nibble_seq.sv
// tb_alu16_nibble_seq: randomized and directed checks of alu16_nibble_seq against an arithmetic reference model
module tb_alu16_nibble_seq;
  logic clk = 0, rst = 1, req_valid = 0, rsp_ready = 0;
  logic [15:0] req_a = 0, req_b = 0;
  logic [1:0] req_op = 0;
  logic req_ready, rsp_valid, rsp_error;
  logic [15:0] rsp_result;
  int n_chk = 0, n_pass = 0, cyc = 0;
  typedef struct {logic [15:0] a; logic [15:0] b; logic [1:0] op; int t;} op_t;
  op_t pend[$], infl[$];
  always #5 clk = ~clk;
  alu16_nibble_seq dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_error(rsp_error)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask
  function automatic logic [16:0] ref_op(input op_t o);
    logic [15:0] r;
    logic e;
    r = o.op == 0 ? ~(o.a & o.b) : o.op == 1 ? o.a ^ o.b : o.op == 2 ? o.a + o.b : o.a - o.b;
    e = o.op == 2 ? (o.a[15] == o.b[15] && r[15] != o.a[15]) :
        o.op == 3 ? (o.a[15] != o.b[15] && r[15] != o.a[15]) : 1'b0;
    return {e, r};
  endfunction
  function automatic int lat(input logic [1:0] op);
`ifdef ALU16_SEQ_FASTLOGIC_EN
    return op[1] ? 4 : 1;
`else
    return 4;
`endif
  endfunction
  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    op_t o;
    o.a = a;
    o.b = b;
    o.op = op;
    o.t = 0;
    pend.push_back(o);
  endtask
  task automatic run(input int mode);
    int bound = 0, wait_n = 0;
    logic prv = 0, hs = 0, hold = 0;
    logic [16:0] held = 0;
    op_t o;
    while ((pend.size() != 0 || infl.size() != 0) && bound < 5000) begin
      @(posedge clk); #1;
      bound++;
      cyc++;
      if (hs) begin
        chk("rdy_after_hs", req_ready, 1);
        chk("valid_drop", rsp_valid, 0);
      end
      if (hold) chk("hold_stable", {rsp_error, rsp_result}, held);
      hs = 0;
      hold = 0;
      if (rsp_valid) begin
        chk("busy_not_ready", req_ready, 0);
        if (!prv) begin
          wait_n = 0;
          if (infl.size() != 0) chk("latency", cyc - infl[0].t, lat(infl[0].op) + 1);
        end
        wait_n++;
        rsp_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : wait_n > 10;
        if (rsp_ready) begin
          if (infl.size() != 0) begin
            o = infl.pop_front();
            chk("result", {rsp_error, rsp_result}, ref_op(o));
          end else chk("spurious_rsp", 1, 0);
          hs = 1;
        end else begin
          hold = 1;
          held = {rsp_error, rsp_result};
        end
      end else rsp_ready = 1'($urandom_range(0, 1));
      prv = rsp_valid;
      if (req_ready && pend.size() != 0) begin
        o = pend.pop_front();
        o.t = cyc;
        infl.push_back(o);
        req_valid = 1;
        req_a = o.a;
        req_b = o.b;
        req_op = o.op;
      end else begin
        req_valid = req_ready ? 1'b0 : 1'($urandom_range(0, 1));
        req_a = 16'($urandom);
        req_b = 16'($urandom);
        req_op = 2'($urandom);
      end
    end
    if (bound >= 5000) chk("timeout", 0, 1);
    req_valid = 0;
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_error", rsp_error, 0);
    chk("rst_ready", req_ready, 0);
    rst = 0;
    #1;
    chk("ready_after_rst", req_ready, 1);
    push(16'h7FFF, 16'h0001, 2);
    push(16'h0FFF, 16'h0001, 2);
    push(16'h0000, 16'h0001, 3);
    push(16'h8000, 16'h0001, 3);
    push(16'hF0F0, 16'hFF00, 0);
    push(16'h1234, 16'hFFFF, 1);
    run(0);
    push(16'h4000, 16'h4000, 2);
    push(16'hABCD, 16'h1357, 1);
    push(16'h8000, 16'h8000, 2);
    run(2);
    for (int i = 0; i < 20 && !req_ready; i++) begin
      @(posedge clk); #1;
    end
    req_a = 16'h1111;
    req_b = 16'h2222;
    req_op = 2;
    req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    chk("midrst_valid", rsp_valid, 0);
    chk("midrst_result", rsp_result, 0);
    chk("midrst_error", rsp_error, 0);
    chk("midrst_ready", req_ready, 0);
    rst = 0;
    #1;
    chk("midrst_idle", req_ready, 1);
    push(16'h0001, 16'h0001, 2);
    run(0);
    for (int i = 0; i < 40; i++) push(16'($urandom), 16'($urandom), 2'($urandom));
    run(1);
    for (int i = 0; i < 20; i++) push(16'($urandom), 16'($urandom), 2'($urandom));
    run(0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu16_nibble_seq.md
# alu16_nibble_seq

Operation issuer for the 4-bit ALU datapath. It accepts 16-bit NAND/XOR/ADD/SUB requests over a valid/ready handshake and walks them through a 4-bit slice one nibble per cycle, least-significant nibble first. It chains the carry between nibbles and returns a registered 16-bit result plus a signed-overflow error flag over a second valid/ready handshake. The block sits between the instruction front end and register writeback wherever 16-bit arithmetic is built from the 4-bit ALU encoding.

## Interface
Parameters: none. Width is fixed at 16 bits (4 nibbles).

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_a  in  16  operand A
- req_b  in  16  operand B
- req_op  in  2  opcode: 00 NAND, 01 XOR, 10 ADD, 11 SUB
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts the result
- rsp_result  out  16  registered result
- rsp_error  out  1  signed 16-bit overflow for ADD/SUB; always 0 for NAND/XOR

## Operation
- **States.** IDLE, EXEC, DONE.
- **IDLE.**
  - req_ready=1.
  - On req_valid&req_ready: latch req_a, req_b and req_op; clear nibble counter k=0; carry=req_op[0]; go to EXEC.
- **EXEC.** Each cycle computes nibble k (bits 4k+3:4k).
  - NAND: ~(a&b).
  - XOR: a^b.
  - ADD: a+b+carry.
  - SUB: a+~b+carry. Carry is seeded to 1, giving two's complement subtraction.
  - Nibble results are written into the result register, the carry-out is registered as next carry, and k increments.
  - After k=3: go to DONE.
- **Error.** On k=3 for ADD/SUB, rsp_error = carry into bit 15 XOR carry out of bit 15. For NAND/XOR, rsp_error=0.
- **DONE.**
  - rsp_valid=1. rsp_result and rsp_error are held stable until rsp_valid&rsp_ready.
  - Then go to IDLE. rsp_valid drops the following cycle.
- **Acceptance.** req_ready=1 only in IDLE. Requests presented in EXEC or DONE are not accepted and are not dropped by the block; the requester holds them.
- **Arithmetic.** Modulo 2^16; the final carry out is discarded except for the overflow computation.
- **Input stability.** Operands and opcode are captured at acceptance. Changes on req_* after acceptance have no effect on the operation in flight.
- **Reset.** rst overrides everything, including mid-EXEC and DONE.
  - State goes to IDLE; k=0; carry=0.
  - rsp_valid=0, rsp_result=0x0000, rsp_error=0.
  - req_ready=0 while rst is high.

## Timing
- **Reset values.** req_ready=0 during reset and 1 in the first cycle after rst deasserts. rsp_valid=0, rsp_result=0x0000, rsp_error=0.
- **Latency.** rsp_valid rises after the 4th rising edge following the accepting edge. With ALU16_SEQ_FASTLOGIC_EN defined, NAND/XOR take 1 edge instead (see Configuration).
- **Throughput.**
  - Minimum 6 cycles per operation with rsp_ready tied high: 1 accept, 4 EXEC, 1 DONE.
  - The next req_ready=1 comes in the cycle after the response handshake.
- **Outputs.** All outputs are registered; no combinational path from req_* or rsp_ready to any output.
- **Backpressure.** rsp_ready low holds DONE indefinitely, with result and error unchanged.
- **Intermediate values.** rsp_result may show partial nibbles during EXEC but is only valid when rsp_valid=1.

## Configuration
- **ALU16_SEQ_FASTLOGIC_EN defined:**
  - NAND/XOR compute all 16 bits in the single EXEC cycle and go directly to DONE. rsp_valid rises 1 edge after acceptance.
  - ADD/SUB are unchanged at 4 nibble cycles.
- **Undefined:** all four opcodes use the 4-cycle nibble walk.

## Test plan
- **ADD overflow:** 0x7FFF + 0x0001 -> rsp_result=0x8000, rsp_error=1, rsp_valid exactly 4 edges after acceptance.
- **Carry chain and SUB:**
  - ADD 0x0FFF + 0x0001 -> 0x1000, error 0.
  - SUB 0x0000 - 0x0001 -> 0xFFFF, error 0.
  - SUB 0x8000 - 0x0001 -> 0x7FFF, error 1.
- **Logic ops:**
  - NAND 0xF0F0, 0xFF00 -> 0x0FFF, error 0.
  - XOR 0x1234, 0xFFFF -> 0xEDCB, error 0.
  - Latency is 4 edges without the macro and 1 edge with ALU16_SEQ_FASTLOGIC_EN.
- **Backpressure:**
  - Hold rsp_ready=0 for 10 cycles in DONE -> rsp_valid=1, result and error constant, req_ready=0 throughout.
  - A req_valid held high during this window is accepted only in the cycle after the response handshake.
- **Reset mid-op:**
  - Assert rst for 1 cycle after 2 EXEC cycles of ADD 0x1111 + 0x2222 -> next cycle rsp_valid=0, rsp_result=0x0000, rsp_error=0, state IDLE.
  - Then ADD 0x0001 + 0x0001 -> 0x0002.
- **Back-to-back with input churn:**
  - Two queued ops, with req_a/req_b toggled during EXEC -> each result reflects only its captured operands.
  - Responses arrive in order, 6 cycles apart with rsp_ready=1.
